// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: instruction FIFO, write-back scoreboard and RAW-hazard hold
// in front of the fixed-latency register-bank ALU pipeline.
module pipe_issue_ctrl #(
    parameter int DEPTH    = 4,
    parameter int WB_LAT   = 3,
    parameter int MAX_FUNC = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    output logic        out_valid,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_func,
    output logic [7:0]  out_addr,
    output logic        err_illegal,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] MAX_F = 4'(MAX_FUNC);

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   head;
    logic [3:0]    h_rs1, h_rs2, h_rd, h_func;
    logic          empty, full, push, pop, issue, illegal_h, hazard, stall_inc;

    logic [WB_LAT-1:0] sb_v_q;
    logic [3:0]        sb_rd_q [WB_LAT];

    logic          out_valid_q, out_valid_d, err_q, err_d;
    logic [23:0]   out_data_q, out_data_d;
    logic [15:0]   stall_q, stall_d;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head   = mem_q[rd_ptr_q[AW-1:0]];
    assign h_rs1  = head[23:20];
    assign h_rs2  = head[19:16];
    assign h_rd   = head[15:12];
    assign h_func = head[11:8];

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_v_q[i] && ((sb_rd_q[i] == h_rs1) || (sb_rd_q[i] == h_rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    // Illegal ops are dropped even if their sources are still in flight.
    assign illegal_h = !empty && (h_func > MAX_F);
    assign issue     = !empty && !illegal_h && !hazard;
    assign stall_inc = !empty && !illegal_h && hazard;
    assign pop       = issue || illegal_h;
    assign push      = in_valid && !full;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        out_valid_d = issue;
        out_data_d  = issue ? head : 24'd0;
        err_d       = illegal_h;
        stall_d     = (stall_inc && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sb_v_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 24'd0;
            err_q       <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sb_v_q      <= {sb_v_q[WB_LAT-2:0], issue};
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

    // Payload storage is qualified by the valid bits above, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
        end
        sb_rd_q[0] <= h_rd;
        for (int i = 1; i < WB_LAT; i++) begin
            sb_rd_q[i] <= sb_rd_q[i-1];
        end
    end

    assign in_ready    = !full;
    assign busy        = !empty || (|sb_v_q);
    assign out_valid   = out_valid_q;
    assign out_rs1     = out_data_q[23:20];
    assign out_rs2     = out_data_q[19:16];
    assign out_rd      = out_data_q[15:12];
    assign out_func    = out_data_q[11:8];
    assign out_addr    = out_data_q[7:0];
    assign err_illegal = err_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus random traffic against a
// time-based reference model (register readable WB_LAT+1 edges after its producer issued).
module tb_pipe_issue_ctrl;

    localparam int DEPTH = 4, WB_LAT = 3, MAX_FUNC = 11;

    typedef struct packed {
        logic [3:0] rs1, rs2, rd, func;
        logic [7:0] addr;
    } instr_t;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready;
    logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0]  in_addr = '0;
    logic        out_valid, err_illegal, busy;
    logic [3:0]  out_rs1, out_rs2, out_rd, out_func;
    logic [7:0]  out_addr;
    logic [15:0] stall_cnt;

    int nchk = 0, nfail = 0;

    pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .MAX_FUNC(MAX_FUNC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_func(out_func), .out_addr(out_addr), .err_illegal(err_illegal), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    instr_t      m_q[$];
    instr_t      stim[$];
    int          last_iss[16];
    int          mcyc = 0;
    logic        m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_ready = 1'b1, m_acc = 1'b0;
    instr_t      m_out = '0;
    logic [15:0] m_stall = 16'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            for (int r = 0; r < 16; r++) last_iss[r] = -1000;
            m_valid = 1'b0; m_out = '0; m_err = 1'b0; m_stall = 16'd0;
            m_ready = 1'b1; m_busy = 1'b0; m_acc = 1'b0;
        end else begin
            int     nb;
            instr_t h;
            nb = m_q.size();
            m_valid = 1'b0; m_out = '0; m_err = 1'b0; m_acc = 1'b0;
            if (nb > 0) begin
                h = m_q[0];
                if (int'(h.func) > MAX_FUNC) begin
                    void'(m_q.pop_front());
                    m_err = 1'b1;
                end else if ((mcyc - last_iss[h.rs1] <= WB_LAT) || (mcyc - last_iss[h.rs2] <= WB_LAT)) begin
                    if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
                end else begin
                    void'(m_q.pop_front());
                    m_valid = 1'b1;
                    m_out = h;
                    last_iss[h.rd] = mcyc;
                end
            end
            if (in_valid && nb < DEPTH) begin
                m_q.push_back(instr_t'({in_rs1, in_rs2, in_rd, in_func, in_addr}));
                m_acc = 1'b1;
            end
            m_ready = (m_q.size() < DEPTH);
            m_busy = (m_q.size() > 0);
            for (int r = 0; r < 16; r++) if (mcyc - last_iss[r] < WB_LAT) m_busy = 1'b1;
            mcyc++;
        end
    end

    function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int func, input int addr);
        instr_t t;
        t.rs1 = 4'(rs1); t.rs2 = 4'(rs2); t.rd = 4'(rd); t.func = 4'(func); t.addr = 8'(addr);
        return t;
    endfunction

    // Advance to the next falling edge, retire the accepted stimulus and present the next one.
    task automatic tick_drive(input int gap);
        @(negedge clk);
        if (m_acc && stim.size() > 0) void'(stim.pop_front());
        if (stim.size() > 0 && int'($urandom_range(99)) >= gap) begin
            in_valid = 1'b1;
            {in_rs1, in_rs2, in_rd, in_func, in_addr} = stim[0];
        end else begin
            in_valid = 1'b0;
            {in_rs1, in_rs2, in_rd, in_func, in_addr} = 24'($urandom);
        end
    endtask

    task automatic do_reset();
        stim.delete();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nchk++;
        if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr} !== 25'd0) begin
            nfail++; $display("FAIL reset_out: got %h want 0", {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr});
        end
        nchk++;
        if ({err_illegal, busy, in_ready, stall_cnt} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
            nfail++; $display("FAIL reset_status: err=%b busy=%b rdy=%b stall=%0d want 0 0 1 0", err_illegal, busy, in_ready, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int vi[$];
        do_reset();
        stim.push_back(mk(3, 5, 10, 0, 8'h11));
        stim.push_back(mk(7, 3, 13, 1, 8'h22));
        for (int i = 0; i < 10; i++) begin
            tick_drive(0);
            nchk++;
            if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr} !== {m_valid, m_out}) begin
                nfail++; $display("FAIL b2b_out cyc%0d: got %h want %h", i, {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr}, {m_valid, m_out});
            end
            if (out_valid) vi.push_back(i);
        end
        nchk++;
        if (vi.size() != 2 || vi[0] != 2 || vi[1] != 3) begin
            nfail++; $display("FAIL b2b_timing: got %0d issues first at %0d want 2 issues at 2,3", vi.size(), (vi.size() > 0) ? vi[0] : -1);
        end
        nchk++;
        if (stall_cnt !== 16'd0) begin
            nfail++; $display("FAIL b2b_stall: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_raw(input instr_t p, input instr_t d, input string nm);
        int vi[$];
        do_reset();
        stim.push_back(p);
        stim.push_back(d);
        for (int i = 0; i < 14; i++) begin
            tick_drive(0);
            nchk++;
            if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr} !== {m_valid, m_out}) begin
                nfail++; $display("FAIL %s_out cyc%0d: got %h want %h", nm, i, {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr}, {m_valid, m_out});
            end
            if (out_valid) vi.push_back(i);
        end
        nchk++;
        if (vi.size() != 2 || vi[1] - vi[0] != WB_LAT + 1) begin
            nfail++; $display("FAIL %s_spacing: got %0d issues spacing %0d want 2 spacing %0d", nm, vi.size(), (vi.size() == 2) ? vi[1] - vi[0] : -1, WB_LAT + 1);
        end
        nchk++;
        if (stall_cnt !== 16'd3) begin
            nfail++; $display("FAIL %s_stall: got %0d want 3", nm, stall_cnt);
        end
    endtask

    task automatic test_chain();
        int rds[$];
        int last_v = -1, fall = -1;
        bit saw_full = 0;
        do_reset();
        for (int k = 1; k <= 6; k++) stim.push_back(mk(k, 0, k + 1, 0, k));
        for (int i = 0; i < 45; i++) begin
            tick_drive(0);
            nchk++;
            if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr} !== {m_valid, m_out}) begin
                nfail++; $display("FAIL chain_out cyc%0d: got %h want %h", i, {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr}, {m_valid, m_out});
            end
            nchk++;
            if ({busy, in_ready, stall_cnt} !== {m_busy, m_ready, m_stall}) begin
                nfail++; $display("FAIL chain_status cyc%0d: busy=%b rdy=%b stall=%0d want %b %b %0d", i, busy, in_ready, stall_cnt, m_busy, m_ready, m_stall);
            end
            if (!in_ready) saw_full = 1;
            if (out_valid) begin rds.push_back(int'(out_rd)); last_v = i; end
            if (!busy && fall < 0 && rds.size() == 6) fall = i;
        end
        nchk++;
        if (!saw_full) begin nfail++; $display("FAIL chain_full: in_ready never 0 want 0 while 4 held"); end
        nchk++;
        if (rds.size() != 6) begin
            nfail++; $display("FAIL chain_count: got %0d issues want 6", rds.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                nchk++;
                if (rds[k] != k + 2) begin nfail++; $display("FAIL chain_order[%0d]: got rd %0d want %0d", k, rds[k], k + 2); end
            end
        end
        nchk++;
        if (fall - last_v != WB_LAT) begin
            nfail++; $display("FAIL chain_busy_fall: got %0d cycles want %0d", fall - last_v, WB_LAT);
        end
    endtask

    task automatic test_illegal();
        int nerr = 0, nv = 0;
        bit saw14 = 0;
        do_reset();
        stim.push_back(mk(1, 2, 3, 0, 8'hA1));
        stim.push_back(mk(4, 5, 6, 14, 8'hA2));
        stim.push_back(mk(7, 8, 9, 1, 8'hA3));
        for (int i = 0; i < 10; i++) begin
            tick_drive(0);
            nchk++;
            if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr, err_illegal} !== {m_valid, m_out, m_err}) begin
                nfail++; $display("FAIL illegal_out cyc%0d: got %h err=%b want %h err=%b", i, {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr}, err_illegal, {m_valid, m_out}, m_err);
            end
            if (err_illegal) nerr++;
            if (out_valid) nv++;
            if (out_func == 4'd14) saw14 = 1;
        end
        nchk++;
        if (nerr != 1 || nv != 2 || saw14) begin
            nfail++; $display("FAIL illegal_summary: pulses=%0d issues=%0d func14_seen=%0d want 1 2 0", nerr, nv, saw14);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        do_reset();
        stim.push_back(mk(1, 1, 2, 0, 8'h01));
        for (int k = 0; k < 3; k++) stim.push_back(mk(2, 0, 5 + k, 1, k));
        while (!(stim.size() == 0 && m_q.size() == 3) && guard < 12) begin
            tick_drive(0);
            guard++;
        end
        nchk++;
        if (guard >= 12 || !busy || stall_cnt == 16'd0) begin
            nfail++; $display("FAIL midrst_setup: guard=%0d busy=%b stall=%0d want queued+busy+stalled", guard, busy, stall_cnt);
        end
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        nchk++;
        if ({out_valid, in_ready, busy, stall_cnt} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
            nfail++; $display("FAIL midrst_immediate: vld=%b rdy=%b busy=%b stall=%0d want 0 1 0 0", out_valid, in_ready, busy, stall_cnt);
        end
        stim.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_drive(0);
            nchk++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                nfail++; $display("FAIL midrst_after cyc%0d: vld=%b busy=%b want 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i < 560 && stim.size() < 2) begin
                int f;
                f = ($urandom_range(7) == 0) ? int'($urandom_range(15, 12)) : int'($urandom_range(11, 0));
                stim.push_back(mk(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)), f, int'($urandom_range(255))));
            end
            tick_drive(30);
            nchk++;
            if ({out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr} !== {m_valid, m_out}) begin
                nfail++; $display("FAIL rand_out cyc%0d: got %h want %h", i, {out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr}, {m_valid, m_out});
            end
            nchk++;
            if ({err_illegal, busy, in_ready, stall_cnt} !== {m_err, m_busy, m_ready, m_stall}) begin
                nfail++; $display("FAIL rand_status cyc%0d: err=%b busy=%b rdy=%b stall=%0d want %b %b %b %0d", i, err_illegal, busy, in_ready, stall_cnt, m_err, m_busy, m_ready, m_stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw(mk(3, 5, 10, 0, 8'h10), mk(10, 5, 14, 1, 8'h20), "raw_rs1");
        test_raw(mk(3, 8, 12, 2, 8'h30), mk(1, 12, 2, 0, 8'h40), "raw_rs2");
        test_chain();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
